// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared types and constants for the Simon sequence datapath
package simon_pkg;

  localparam int SEQ_DEPTH = 32;

  typedef logic [2:0] seg_t;
  typedef logic [1:0] colour_t;

  localparam seg_t SEG_EMPTY = 3'b100;

  typedef enum logic [1:0] {
    READY = 2'd0,
    WIPE  = 2'd1,
    FULL  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) with seed load
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        load_i,
  input  logic [15:0] seed_i,
  output logic [15:0] state_o
);

  logic [15:0] state_q, state_d;
  logic        fb;

  assign fb = state_q[0] ^ state_q[2] ^ state_q[3] ^ state_q[5];

  always_comb begin
    state_d = state_q;
    // An all-zero state would lock up, so a zero seed falls back to SEED
    if (load_i)    state_d = (seed_i == 16'h0000) ? SEED : seed_i;
    else if (en_i) state_d = {fb, state_q[15:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SEED;
    else        state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/sequence_builder.sv
// rtl/sequence_builder.sv - builds the 32-entry Simon colour table; SEQ_NO_REPEAT_EN forbids back-to-back repeats
module sequence_builder
  import simon_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          append_req,
  output logic                          append_ack,
  input  logic                          seed_load,
  input  logic [15:0]                   seed,
  output logic [SEQ_DEPTH-1:0][2:0]     segment,
  output logic [5:0]                    length,
  output logic                          busy,
  output logic                          full
);

  seq_state_t                   state_q, state_d;
  logic [SEQ_DEPTH-1:0][2:0]    seg_q, seg_d;
  logic [5:0]                   len_q, len_d;
  logic [4:0]                   wcnt_q, wcnt_d;
  logic                         ack_q, ack_d;
  logic                         armed_q, armed_d;
  logic [15:0]                  lfsr_state;
  logic                         unused_lfsr;
  colour_t                      cand, colour;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (1'b1),
    .load_i  (seed_load),
    .seed_i  (seed),
    .state_o (lfsr_state)
  );

  assign cand        = lfsr_state[1:0];
  assign unused_lfsr = ^lfsr_state[15:2];

`ifdef SEQ_NO_REPEAT_EN
  logic [4:0] prev_idx;
  assign prev_idx = 5'(len_q - 6'd1);
  assign colour   = (len_q != 6'd0 && cand == seg_q[prev_idx][1:0]) ? colour_t'(cand + 2'd1) : cand;
`else
  assign colour   = cand;
`endif

  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    ack_d   = 1'b0;
    // A held request re-arms only after being seen low for a cycle
    armed_d = armed_q | ~append_req;
    if (clear) begin
      state_d = WIPE;
      wcnt_d  = 5'd0;
      len_d   = 6'd0;
    end else begin
      case (state_q)
        WIPE: begin
          seg_d[wcnt_q] = SEG_EMPTY;
          wcnt_d        = wcnt_q + 5'd1;
          if (wcnt_q == 5'd31) state_d = READY;
        end
        READY: begin
          if (append_req && armed_q) begin
            seg_d[len_q[4:0]] = {1'b0, colour};
            len_d             = len_q + 6'd1;
            ack_d             = 1'b1;
            armed_d           = 1'b0;
            if (len_q == 6'd31) state_d = FULL;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= READY;
      seg_q   <= {SEQ_DEPTH{SEG_EMPTY}};
      len_q   <= 6'd0;
      wcnt_q  <= 5'd0;
      ack_q   <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      ack_q   <= ack_d;
      armed_q <= armed_d;
    end
  end

  assign segment    = seg_q;
  assign length     = len_q;
  assign append_ack = ack_q;
  assign busy       = (state_q == WIPE);
  assign full       = (state_q == FULL);

endmodule

// File: tb/tb_sequence_builder.sv
// tb/tb_sequence_builder.sv - scoreboard bench for sequence_builder with a behavioural LFSR/table model
module tb_sequence_builder;
  import simon_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        append_req = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed = 16'h0000;
  logic        append_ack;
  logic [31:0][2:0] segment;
  logic [5:0]  length;
  logic        busy;
  logic        full;

  sequence_builder dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .append_req(append_req),
    .append_ack(append_ack), .seed_load(seed_load), .seed(seed),
    .segment(segment), .length(length), .busy(busy), .full(full)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] m_lfsr, m_prev;
  logic [2:0]  tbl [32];
  int          exp_q [$];
  int          len_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] x);
    int v, b;
    v = int'(x);
    b = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
    return 16'((v >> 1) | (b << 15));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= seed_load ? ((seed == 16'h0000) ? 16'hACE1 : seed) : lstep(m_lfsr);
    end
  end

  always @(negedge clk) begin : monitor
    int         idx;
    logic [1:0] c;
    if (rst_n && append_ack) begin
      chk("ack_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        idx = exp_q.pop_front();
        c   = m_prev[1:0];
`ifdef SEQ_NO_REPEAT_EN
        if (idx > 0 && c == tbl[idx-1][1:0]) c = c + 2'd1;
`endif
        tbl[idx] = {1'b0, c};
        chk("append_entry", 32'(segment[idx]), 32'(tbl[idx]));
        chk("append_length", 32'(length), 32'(idx + 1));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wipe_model();
    for (int i = 0; i < 32; i++) tbl[i] = SEG_EMPTY;
    len_m = 0;
  endtask

  task automatic check_table(input string name);
    for (int i = 0; i < 32; i++) chk(name, 32'(segment[i]), 32'(tbl[i]));
  endtask

  task automatic do_append(input bit expect_ack, input int hold, output int acks);
    if (expect_ack) begin
      exp_q.push_back(len_m);
      len_m++;
    end
    append_req = 1'b1;
    acks = 0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (append_ack) acks++;
    end
    append_req = 1'b0;
    tick();
    if (append_ack) acks++;
  endtask

  task automatic clear_and_wait(output int busy_cycles);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    wipe_model();
    busy_cycles = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      busy_cycles++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acks, bc, early;
    logic [2:0] exp_nr;
    wipe_model();
    repeat (2) tick();
    check_table("reset_segment");
    chk("reset_length", 32'(length), 0);
    chk("reset_full", 32'(full), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_ack", 32'(append_ack), 0);
    chk("reset_lfsr", 32'(dut.u_lfsr.state_o), 32'h0000ACE1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("lfsr_free_run", 32'(dut.u_lfsr.state_o), 32'(m_lfsr));
    end

    seed_load = 1'b1; seed = 16'h0000;
    tick();
    seed_load = 1'b0;
    chk("seed_zero_subst", 32'(dut.u_lfsr.state_o), 32'h0000ACE1);

    seed_load = 1'b1; seed = 16'h0001;
    tick();
    seed_load = 1'b0;
    chk("seed_one", 32'(dut.u_lfsr.state_o), 32'h00000001);
    do_append(1'b1, 4, acks);
    chk("held_req_single_ack", acks, 1);
    chk("seeded_first_entry", 32'(segment[0]), 32'h1);
    do_append(1'b1, 1, acks);
    chk("rearm_ack", acks, 1);
    chk("rearm_length", 32'(length), 2);

    for (int k = 2; k < 32; k++) begin
      seed_load = ($urandom_range(0, 3) == 0);
      seed = 16'($urandom);
      tick();
      seed_load = 1'b0;
      do_append(1'b1, $urandom_range(1, 3), acks);
      chk("fill_ack", acks, 1);
    end
    chk("full_flag", 32'(full), 1);
    chk("full_length", 32'(length), 32);
    do_append(1'b0, 4, acks);
    chk("full_no_ack", acks, 0);
    check_table("full_table_unchanged");
    chk("full_length_hold", 32'(length), 32);

    clear_and_wait(bc);
    chk("first_wipe_cycles", bc, 32);
    for (int k = 0; k < 10; k++) begin
      do_append(1'b1, 1, acks);
      chk("len10_ack", acks, 1);
    end
    chk("len10_length", 32'(length), 10);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    wipe_model();
    chk("wipe_length_zero", 32'(length), 0);
    exp_q.push_back(0);
    len_m = 1;
    append_req = 1'b1;
    bc = 0;
    early = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      bc++;
      if (append_ack) early++;
      tick();
    end
    chk("busy_cycles", bc, 32);
    chk("ack_during_wipe", early, 0);
    check_table("wiped_table");
    chk("wiped_length", 32'(length), 0);
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (append_ack) acks++;
    end
    append_req = 1'b0;
    chk("ack_after_wipe", acks, 1);
    tick();

    append_req = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    append_req = 1'b0;
    wipe_model();
    chk("clear_wins_no_ack", 32'(append_ack), 0);
    chk("clear_wins_busy", 32'(busy), 1);
    repeat (15) tick();
    rst_n = 1'b0;
    #1;
    check_table("reset_mid_wipe");
    chk("reset_mid_wipe_busy", 32'(busy), 0);
    chk("reset_mid_wipe_length", 32'(length), 0);
    chk("reset_mid_wipe_lfsr", 32'(dut.u_lfsr.state_o), 32'h0000ACE1);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("ready_after_reset", 32'(busy), 0);
    do_append(1'b1, 1, acks);
    chk("append_after_reset", acks, 1);

    clear_and_wait(bc);
    seed_load = 1'b1; seed = 16'h0003;
    tick();
    seed_load = 1'b0;
    do_append(1'b1, 1, acks);
    chk("norepeat_first", 32'(segment[0]), 32'h3);
    seed_load = 1'b1; seed = 16'h0007;
    tick();
    seed_load = 1'b0;
    do_append(1'b1, 1, acks);
`ifdef SEQ_NO_REPEAT_EN
    exp_nr = 3'b000;
`else
    exp_nr = 3'b011;
`endif
    chk("norepeat_second", 32'(segment[1]), 32'(exp_nr));

    repeat (3) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
